seg7_scan_display: RTL and testbench

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a packed hex word on a load strobe and scans one digit per scan tick. Per digit it supports decimal points, leading-zero blanking and blinking. It sits between the calculator datapath (result word) and the board's digit-enable and segment pins.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_display.sv | 132 +++++++++++++
 tb/tb_seg7_scan_display.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment encodings and counter-width helper.
// Pure declarations; no timing or flow control involved.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {a,b,c,d,e,f,g}, a in the MSB, indexed by hex value.
  localparam logic [6:0] SEG_DECODE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h72, 7'h42, 7'h30, 7'h38
  };

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern; zero latency, no flow control.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_DECODE[i_nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode digit driver: one digit slot per SCAN_DIV cycles, outputs registered on each tick.
// Load is a fire-and-forget strobe accepted every cycle; new content shows from the next tick.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 20000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   led_en,
  output logic [6:0]              seg,
  output logic                    led_dp
);

  localparam int SW = clog2_min1(SCAN_DIV);
  localparam int BW = clog2_min1(BLINK_DIV);
  localparam int IW = clog2_min1(NUM_DIGITS);

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blink;
  logic [SW-1:0]           r_scan;
  logic [BW-1:0]           r_blink_cnt;
  logic                    r_phase;
  logic [IW-1:0]           r_idx;
  logic [NUM_DIGITS-1:0]   r_led_en;
  logic [6:0]              r_seg;
  logic                    r_led_dp;

  logic                    w_tick;
  logic [NUM_DIGITS-1:0]   w_lit;
  logic [NUM_DIGITS-1:0]   w_en_next;
  logic [3:0]              w_nibble;
  logic                    w_dp_sel;
  logic                    w_blink_sel;
  logic                    w_lit_sel;
  logic                    w_blank;
  logic                    w_blink_off;
  logic [6:0]              w_seg_dec;
  logic                    w_acc;

  assign w_tick = (r_scan == SCAN_LAST);

  // w_lit[i]: some nibble at position i or above is nonzero, i.e. digit i is not a leading zero.
  always_comb begin
    w_lit = '0;
    w_acc = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_acc    = w_acc | (|r_data[4*i +: 4]);
      w_lit[i] = w_acc;
    end
  end

  always_comb begin
    w_nibble    = 4'h0;
    w_dp_sel    = 1'b0;
    w_blink_sel = 1'b0;
    w_lit_sel   = 1'b0;
    w_en_next   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nibble     = r_data[4*i +: 4];
        w_dp_sel     = r_dp[i];
        w_blink_sel  = r_blink[i];
        w_lit_sel    = w_lit[i];
        w_en_next[i] = 1'b0;
      end
    end
  end

  // Digit 0 always shows, so a zero result still displays "0".
  assign w_blank     = blank_lz && (r_idx != '0) && !w_lit_sel;
  assign w_blink_off = r_phase && w_blink_sel;

  seg7_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_dp        <= '0;
      r_blink     <= '0;
      r_scan      <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_idx       <= '0;
      r_led_en    <= '1;
      r_seg       <= SEG_OFF;
      r_led_dp    <= 1'b1;
    end else begin
      if (load) begin
        r_data  <= data;
        r_dp    <= dp_mask;
        r_blink <= blink_mask;
      end

      r_scan <= w_tick ? '0 : r_scan + SW'(1);

      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end

      if (w_tick) begin
        r_idx    <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        r_led_en <= w_en_next;
        r_seg    <= (w_blank || w_blink_off) ? SEG_OFF : w_seg_dec;
        r_led_dp <= w_blink_off ? 1'b1 : ~w_dp_sel;
      end
    end
  end

  assign led_en = r_led_en;
  assign seg    = r_seg;
  assign led_dp = r_led_dp;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized bench for seg7_scan_display: cycle-count arithmetic model plus hand-computed literal checks.
module tb_seg7_scan_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 64;

  localparam logic [6:0] TBL [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h72, 7'h42, 7'h30, 7'h38
  };

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        load     = 1'b0;
  logic [15:0] data     = '0;
  logic [3:0]  dp_mask  = '0;
  logic [3:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  led_en;
  logic [6:0]  seg;
  logic        led_dp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data       (data),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .led_en     (led_en),
    .seg        (seg),
    .led_dp     (led_dp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: e = rising edges since reset release. A slot registers on every SD-th edge.
  int          e      = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp   = '0;
  logic [3:0]  m_bl   = '0;
  logic [3:0]  x_en   = 4'hF;
  logic [6:0]  x_seg  = 7'h7F;
  logic        x_dp   = 1'b1;
  int          s_slot;
  int          s_ph;
  logic [3:0]  s_nib;
  logic        s_blank;
  logic        s_boff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e      = 0;
      m_data = '0;
      m_dp   = '0;
      m_bl   = '0;
      x_en   = 4'hF;
      x_seg  = 7'h7F;
      x_dp   = 1'b1;
    end else begin
      e = e + 1;
      if (e % SD == 0) begin
        s_slot  = (e / SD - 1) % ND;
        s_ph    = ((e - 1) / BD) % 2;
        s_nib   = 4'((m_data >> (4 * s_slot)) & 16'hF);
        s_blank = blank_lz && (s_slot >= 1) && ((m_data >> (4 * s_slot)) == 16'h0);
        s_boff  = (s_ph == 1) && m_bl[s_slot];
        x_en    = 4'hF & ~(4'b0001 << s_slot);
        x_seg   = (s_blank || s_boff) ? 7'h7F : TBL[s_nib];
        x_dp    = s_boff ? 1'b1 : ~m_dp[s_slot];
      end
      if (load) begin
        m_data = data;
        m_dp   = dp_mask;
        m_bl   = blink_mask;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_led_en", led_en, x_en);
    chk("m_seg", seg, x_seg);
    chk("m_led_dp", led_dp, x_dp);
  end

  task automatic to_mod(input int m, input int r);
    while (e % m != r) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data       = d;
    dp_mask    = dp;
    blink_mask = bl;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic slot_chk(input string name, input logic [3:0] en, input logic [6:0] sg, input logic dp);
    chk({name, "_en"}, led_en, en);
    chk({name, "_seg"}, seg, sg);
    chk({name, "_dp"}, led_dp, dp);
  endtask

  task automatic reset_then_first();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      slot_chk("post_rst", 4'hF, 7'h7F, 1'b1);
    end
    @(negedge clk);
    slot_chk("first_slot", 4'hE, 7'h01, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_then_first();

    to_mod(16, 0);
    do_load(16'h1A2F, 4'h0, 4'h0);
    to_mod(16, 4);  slot_chk("hex_d0", 4'hE, 7'h38, 1'b1);
    to_mod(16, 8);  slot_chk("hex_d1", 4'hD, 7'h12, 1'b1);
    to_mod(16, 12); slot_chk("hex_d2", 4'hB, 7'h08, 1'b1);
    to_mod(16, 0);  slot_chk("hex_d3", 4'h7, 7'h4F, 1'b1);
    to_mod(16, 4);  slot_chk("hex_rep", 4'hE, 7'h38, 1'b1);

    blank_lz = 1'b1;
    to_mod(16, 0);
    do_load(16'h0050, 4'b0100, 4'h0);
    to_mod(16, 4);  slot_chk("lz_d0", 4'hE, 7'h01, 1'b1);
    to_mod(16, 8);  slot_chk("lz_d1", 4'hD, 7'h24, 1'b1);
    to_mod(16, 12); slot_chk("lz_d2", 4'hB, 7'h7F, 1'b0);
    to_mod(16, 0);  slot_chk("lz_d3", 4'h7, 7'h7F, 1'b1);
    blank_lz = 1'b0;
    to_mod(16, 12); slot_chk("nolz_d2", 4'hB, 7'h01, 1'b0);
    to_mod(16, 0);  slot_chk("nolz_d3", 4'h7, 7'h01, 1'b1);

    to_mod(16, 0);
    do_load(16'h0008, 4'h0, 4'b0001);
    to_mod(128, 68); slot_chk("blink_off", 4'hE, 7'h7F, 1'b1);
    to_mod(128, 72); slot_chk("blink_other", 4'hD, 7'h01, 1'b1);
    to_mod(128, 4);  slot_chk("blink_on", 4'hE, 7'h00, 1'b1);

    to_mod(16, 0);
    do_load(16'h1111, 4'h0, 4'h0);
    to_mod(16, 3);
    do_load(16'h2222, 4'h0, 4'h0);
    slot_chk("coinc_old", 4'hE, 7'h4F, 1'b1);
    to_mod(16, 8);  slot_chk("coinc_new", 4'hD, 7'h12, 1'b1);
    to_mod(16, 10);
    #2 rst_n = 1'b0;
    #1 slot_chk("async_rst", 4'hF, 7'h7F, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    reset_then_first();

    for (int it = 0; it < 3000; it++) begin
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        data       = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_mask    = 4'($urandom);
        blink_mask = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 slot_chk("rnd_rst", 4'hF, 7'h7F, 1'b1);
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    load = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
